// File: rtl/ps2_frame_rx_if.sv
// Bundle between the PS/2 frame receiver and the scan-code lookup stage.
// master = receiver side, slave = consumer side (drives the data line in a bench).
interface ps2_frame_rx_if #(
  parameter int ERR_W = 4
);
  logic             ps_data;
  logic [7:0]       code;
  logic             is_break;
  logic             is_ext;
  logic             code_tgl;
  logic [ERR_W-1:0] err_cnt;
  logic             busy;

  modport master (
    input  ps_data,
    output code, is_break, is_ext, code_tgl, err_cnt, busy
  );

  modport slave (
    output ps_data,
    input  code, is_break, is_ext, code_tgl, err_cnt, busy
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with F0/E0 prefix stripping and toggle handshake.
// Optional macro PS2_PARITY_CHECK_EN: when defined, bad odd parity discards the frame.
module ps2_frame_rx #(
  parameter int ERR_W = 4
) (
  input  logic                  ps_clk,
  input  logic                  rst,
  ps2_frame_rx_if.master        bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  state_t           next_state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par;
  logic             brk_pend;
  logic             ext_pend;
  logic [7:0]       code_q;
  logic             is_break_q;
  logic             is_ext_q;
  logic             code_tgl_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             parity_ok;
  logic             frame_good;

  assign parity_ok = ^{shreg, par};

`ifdef PS2_PARITY_CHECK_EN
  assign frame_good = bus.ps_data & parity_ok;
`else
  // par is still captured, but only the stop bit qualifies the frame
  assign frame_good = bus.ps_data & (parity_ok | 1'b1);
`endif

  always_ff @(negedge ps_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!bus.ps_data) next_state = DATA;
      DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
      PARITY:  next_state = STOP;
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(negedge ps_clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par        <= 1'b0;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
      code_q     <= 8'h00;
      is_break_q <= 1'b0;
      is_ext_q   <= 1'b0;
      code_tgl_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.ps_data) bit_cnt <= 3'd0;
        end
        DATA: begin
          shreg   <= {bus.ps_data, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY: begin
          par <= bus.ps_data;
        end
        STOP: begin
          if (frame_good) begin
            if (shreg == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (shreg == 8'hE0) begin
              ext_pend <= 1'b1;
            end else begin
              code_q     <= shreg;
              is_break_q <= brk_pend;
              is_ext_q   <= ext_pend;
              code_tgl_q <= ~code_tgl_q;
              brk_pend   <= 1'b0;
              ext_pend   <= 1'b0;
            end
          end else begin
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.code     = code_q;
  assign bus.is_break = is_break_q;
  assign bus.is_ext   = is_ext_q;
  assign bus.code_tgl = code_tgl_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: drives PS/2 frames on rising edges, checks after the stop edge.
module tb_ps2_frame_rx;

  localparam int ERR_W = 4;

  logic ps_clk;
  logic rst;
  int   compared;
  int   mismatched;

  logic [7:0] exp_code;
  logic       exp_brk;
  logic       exp_ext;
  logic       exp_tgl;
  logic [3:0] exp_err;

  ps2_frame_rx_if #(.ERR_W(ERR_W)) bus ();

  ps2_frame_rx #(.ERR_W(ERR_W)) dut (
    .ps_clk (ps_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial begin
    ps_clk = 1'b1;
    forever #10 ps_clk = ~ps_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".code"},     32'(bus.code),     32'(exp_code));
    checkOutput({tag, ".is_break"}, 32'(bus.is_break), 32'(exp_brk));
    checkOutput({tag, ".is_ext"},   32'(bus.is_ext),   32'(exp_ext));
    checkOutput({tag, ".code_tgl"}, 32'(bus.code_tgl), 32'(exp_tgl));
    checkOutput({tag, ".err_cnt"},  32'(bus.err_cnt),  32'(exp_err));
    checkOutput({tag, ".busy"},     32'(bus.busy),     32'd0);
  endtask

  // Drives start, 8 data bits LSB first, parity, stop; returns just after the stop edge.
  task automatic applyStimulus(input logic [7:0] b, input logic flip_par, input logic stop_val);
    logic [10:0] frame;
    frame = {stop_val, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge ps_clk);
      bus.ps_data = frame[i];
    end
    @(posedge ps_clk);
    bus.ps_data = 1'b1;
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.ps_data = 1'b1;
    rst = 1'b0;
    exp_code = 8'h00; exp_brk = 1'b0; exp_ext = 1'b0; exp_tgl = 1'b0; exp_err = 4'd0;
    repeat (3) @(posedge ps_clk);
    #1;
    checkAll("reset");
    rst = 1'b1;
    repeat (2) @(posedge ps_clk);

    applyStimulus(8'h1C, 1'b0, 1'b1);
    exp_code = 8'h1C; exp_tgl = 1'b1;
    checkAll("plain_1c");

    applyStimulus(8'hF0, 1'b0, 1'b1);
    checkAll("after_f0");
    applyStimulus(8'h1C, 1'b0, 1'b1);
    exp_brk = 1'b1; exp_tgl = 1'b0;
    checkAll("break_1c");

    applyStimulus(8'hE0, 1'b0, 1'b1);
    checkAll("after_e0");
    applyStimulus(8'hF0, 1'b0, 1'b1);
    checkAll("after_e0_f0");
    applyStimulus(8'h75, 1'b0, 1'b1);
    exp_code = 8'h75; exp_brk = 1'b1; exp_ext = 1'b1; exp_tgl = 1'b1;
    checkAll("ext_break_75");
    applyStimulus(8'h75, 1'b0, 1'b1);
    exp_brk = 1'b0; exp_ext = 1'b0; exp_tgl = 1'b0;
    checkAll("plain_75");

    applyStimulus(8'h1C, 1'b0, 1'b0);
    exp_err = 4'd1;
    checkAll("bad_stop");

    applyStimulus(8'hF0, 1'b0, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    exp_err = 4'd2;
    checkAll("f0_then_bad");
    applyStimulus(8'h1C, 1'b0, 1'b1);
    exp_code = 8'h1C; exp_brk = 1'b0; exp_tgl = 1'b1;
    checkAll("pend_cleared_1c");

    applyStimulus(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    exp_err = 4'd3;
`else
    exp_tgl = 1'b0;
`endif
    checkAll("bad_parity");

    // F0 pending, then a partial 0x32 frame cut off by reset after the 5th data bit
    applyStimulus(8'hF0, 1'b0, 1'b1);
    @(posedge ps_clk); bus.ps_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge ps_clk);
      bus.ps_data = (i == 1 || i == 4) ? 1'b1 : 1'b0;
    end
    @(posedge ps_clk);
    #1;
    checkOutput("mid_frame.busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    bus.ps_data = 1'b1;
    #1;
    exp_code = 8'h00; exp_brk = 1'b0; exp_ext = 1'b0; exp_tgl = 1'b0; exp_err = 4'd0;
    checkAll("mid_reset");
    @(posedge ps_clk);
    rst = 1'b1;
    applyStimulus(8'h32, 1'b0, 1'b1);
    exp_code = 8'h32; exp_tgl = 1'b1;
    checkAll("after_reset_32");

    for (int i = 0; i < 15; i++) applyStimulus(8'h1C, 1'b0, 1'b0);
    exp_err = 4'd15;
    checkAll("err_15");
    applyStimulus(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkAll("err_saturated");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
